// File: rtl/tick_timer_ctrl_pkg.sv
// Shared definitions for the tick timer: state encoding, default widths and
// the reset-divisor computation.
package tick_timer_ctrl_pkg;

  localparam int DEF_DIV_W = 26;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Prescaler terminal that yields tick_hz ticks per second from clk_freq.
  function automatic longint default_div(input longint clk_freq, input longint tick_hz);
    return (clk_freq / tick_hz) - 64'sd1;
  endfunction

endpackage

// File: rtl/tick_timer_ctrl_prescaler.sv
// Programmable prescaler: counts 0..term_i while enabled and emits a registered
// one-cycle wrap pulse; wrap_now_o flags the edge on which the wrap happens.
module tick_prescaler
  import tick_timer_ctrl_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] term_i,
  output logic             wrap_o,
  output logic             wrap_now_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  assign wrap_now_o = en_i & ~clr_i & (cnt_q == term_i);
  assign wrap_o     = wrap_q;

  // Next-state: clear beats enable; a frozen prescaler never emits a pulse.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr_i) begin
      cnt_d  = '0;
      wrap_d = 1'b0;
    end else if (wrap_now_o) begin
      cnt_d  = '0;
      wrap_d = 1'b1;
    end else if (en_i) begin
      cnt_d  = cnt_q + DIV_W'(1);
      wrap_d = 1'b0;
    end else begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
    end
  end

  // Prescaler state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

endmodule

// File: rtl/tick_timer_ctrl.sv
// Timer controller: sequences the prescaler and a tick counter, holds the
// runtime configuration and raises a sticky interrupt at terminal count.
module tick_timer_ctrl
  import tick_timer_ctrl_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_HZ  = 1,
  parameter int DIV_W    = DEF_DIV_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic [CNT_W-1:0] cfg_limit_i,
  input  logic             cfg_periodic_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             pause_i,
  input  logic             irq_clr_i,
  output logic             tick_o,
  output logic [CNT_W-1:0] count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             irq_o
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(default_div(CLK_FREQ, TICK_HZ));

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic             periodic_q, periodic_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             irq_q, irq_d;
  logic             cfg_ready_q, cfg_ready_d;

  logic idle_like_s, run_like_s, start_go_s, active_s;
  logic wrap_now_s, terminal_s, cfg_accept_s;

  assign idle_like_s  = (state_q == ST_IDLE) | (state_q == ST_DONE);
  assign run_like_s   = (state_q == ST_RUN) | (state_q == ST_PAUSE);
  assign start_go_s   = start_i & idle_like_s & ~stop_i;
  // Releasing pause lets the prescaler advance in that same cycle, so the
  // remaining phase is served without an extra cycle of latency.
  assign active_s     = run_like_s & ~pause_i & ~stop_i;
  assign terminal_s   = wrap_now_s & (count_q == limit_q);
  assign cfg_accept_s = cfg_valid_i & cfg_ready_q;

  tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .en_i       (active_s),
    .clr_i      (stop_i | start_go_s),
    .term_i     (div_q),
    .wrap_o     (tick_o),
    .wrap_now_o (wrap_now_s)
  );

  // FSM next state: stop overrides everything, then pause, then terminal.
  always_comb begin
    state_d = state_q;
    if (stop_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) state_d = ST_RUN;
          else         state_d = state_q;
        end
        ST_RUN, ST_PAUSE: begin
          if (pause_i)                         state_d = ST_PAUSE;
          else if (terminal_s && !periodic_q)  state_d = ST_DONE;
          else                                 state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Tick counter, done pulse and sticky irq.
  always_comb begin
    count_d = count_q;
    if (stop_i || start_go_s) begin
      count_d = '0;
    end else if (terminal_s) begin
      count_d = periodic_q ? '0 : count_q;
    end else if (wrap_now_s) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end

    done_d = terminal_s;

    // A clear coinciding with a done (internal or visible) loses.
    if (done_d || done_q) irq_d = 1'b1;
    else if (irq_clr_i)   irq_d = 1'b0;
    else                  irq_d = irq_q;
  end

  // Configuration registers load only while the timer is idle or finished.
  always_comb begin
    div_d       = div_q;
    limit_d     = limit_q;
    periodic_d  = periodic_q;
    cfg_ready_d = (state_d == ST_IDLE) | (state_d == ST_DONE);
    if (cfg_accept_s) begin
      div_d      = cfg_div_i;
      limit_d    = cfg_limit_i;
      periodic_d = cfg_periodic_i;
    end else begin
      div_d      = div_q;
      limit_d    = limit_q;
      periodic_d = periodic_q;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_q       <= DIV_RST;
      limit_q     <= '1;
      periodic_q  <= 1'b1;
      count_q     <= '0;
      done_q      <= 1'b0;
      irq_q       <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      limit_q     <= limit_d;
      periodic_q  <= periodic_d;
      count_q     <= count_d;
      done_q      <= done_d;
      irq_q       <= irq_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign busy_o      = run_like_s;
  assign count_o     = count_q;
  assign done_o      = done_q;
  assign irq_o       = irq_q;
  assign cfg_ready_o = cfg_ready_q;

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Scoreboard bench for tick_timer_ctrl: expected (count, done) per tick is
// queued when stimulus is driven and checked whenever the DUT ticks.
module tb_tick_timer_ctrl;

  localparam int DIV_W = 26;
  localparam int CNT_W = 4;

  logic             clk, rst;
  logic             cfg_valid, cfg_ready, cfg_periodic;
  logic [DIV_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_limit;
  logic             start, stop, pause, irq_clr;
  logic             tick, busy, done, irq;
  logic [CNT_W-1:0] count;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             dn;
  } exp_t;

  exp_t sb_q[$];
  int   vec_cnt = 0;
  int   miscmp_cnt = 0;
  int   n;

  tick_timer_ctrl #(
    .CLK_FREQ (8),
    .TICK_HZ  (1),
    .DIV_W    (DIV_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_valid_i    (cfg_valid),
    .cfg_ready_o    (cfg_ready),
    .cfg_div_i      (cfg_div),
    .cfg_limit_i    (cfg_limit),
    .cfg_periodic_i (cfg_periodic),
    .start_i        (start),
    .stop_i         (stop),
    .pause_i        (pause),
    .irq_clr_i      (irq_clr),
    .tick_o         (tick),
    .count_o        (count),
    .busy_o         (busy),
    .done_o         (done),
    .irq_o          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int budget, output int cycles);
    cycles = 0;
    do begin
      cyc();
      cycles++;
    end while (!tick && cycles < budget);
  endtask

  task automatic push(input int c, input logic d);
    exp_t e;
    e.cnt = CNT_W'(c);
    e.dn  = d;
    sb_q.push_back(e);
  endtask

  task automatic configure(input int dv, input int lim, input logic per);
    cfg_valid    = 1'b1;
    cfg_div      = DIV_W'(dv);
    cfg_limit    = CNT_W'(lim);
    cfg_periodic = per;
    cyc();
    cfg_valid    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  // Scoreboard monitor: every tick consumes one expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (tick) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_tick", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_count", 32'(count), 32'(e.cnt));
          chk("sb_done", 32'(done), 32'(e.dn));
        end
      end else if (done) begin
        chk("sb_done_without_tick", 32'(done), 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_div = '0; cfg_limit = '0; cfg_periodic = 1'b0;
    start = 1'b0; stop = 1'b0; pause = 1'b0; irq_clr = 1'b0;
    #1;
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // Default divisor 8/1-1 = 7: first tick 8 cycles after RUN entry.
    push(1, 1'b0);
    pulse_start();
    wait_tick(50, n);
    chk("def_first_tick_lat", 32'(n), 32'd8);
    pulse_stop();
    chk("def_stop_busy", 32'(busy), 32'd0);

    // Periodic div=3 limit=5: ticks every 4 cycles, count wraps with done.
    configure(3, 5, 1'b1);
    for (int i = 1; i <= 5; i++) push(i, 1'b0);
    push(0, 1'b1);
    pulse_start();
    chk("per_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) begin
      wait_tick(50, n);
      chk("per_tick_period", 32'(n), 32'd4);
    end
    chk("per_irq", 32'(irq), 32'd1);
    chk("per_busy_after_done", 32'(busy), 32'd1);
    irq_clr = 1'b1;
    cyc();
    chk("irq_clr_with_done", 32'(irq), 32'd1);
    cyc();
    chk("irq_clr_alone", 32'(irq), 32'd0);
    irq_clr = 1'b0;
    pulse_stop();
    chk("per_stop_count", 32'(count), 32'd0);
    chk("per_stop_cfg_ready", 32'(cfg_ready), 32'd1);

    // One-shot div=0 limit=2: ticks every cycle, done on third tick, then hold.
    configure(0, 2, 1'b0);
    push(1, 1'b0); push(2, 1'b0); push(2, 1'b1);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      wait_tick(50, n);
      chk("os_tick_period", 32'(n), 32'd1);
    end
    chk("os_busy", 32'(busy), 32'd0);
    chk("os_count_hold", 32'(count), 32'd2);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (done) n++;
    end
    chk("os_extra_done", 32'(n), 32'd0);
    chk("os_count_after", 32'(count), 32'd2);
    irq_clr = 1'b1;
    cyc();
    irq_clr = 1'b0;

    // Pause at prescaler=4 with div=9: remaining 6 cycles served after release.
    configure(9, 15, 1'b1);
    push(1, 1'b0); push(2, 1'b0);
    pulse_start();
    wait_tick(50, n);
    chk("pause_first_tick", 32'(n), 32'd10);
    repeat (4) cyc();
    pause = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (tick || count != 4'd1 || !busy) n++;
    end
    chk("pause_frozen", 32'(n), 32'd0);
    pause = 1'b0;
    wait_tick(50, n);
    chk("pause_resume_lat", 32'(n), 32'd6);
    pulse_stop();

    // Config refused while running; stop wins over start; config accepted after.
    configure(3, 5, 1'b1);
    pulse_start();
    cfg_valid = 1'b1; cfg_div = DIV_W'(0); cfg_limit = CNT_W'(1); cfg_periodic = 1'b0;
    chk("run_cfg_ready", 32'(cfg_ready), 32'd0);
    push(1, 1'b0);
    wait_tick(50, n);
    chk("run_cfg_unchanged", 32'(n), 32'd4);
    cfg_valid = 1'b0;
    stop = 1'b1; start = 1'b1;
    cyc();
    stop = 1'b0; start = 1'b0;
    chk("stopstart_busy", 32'(busy), 32'd0);
    chk("stopstart_count", 32'(count), 32'd0);
    chk("stopstart_tick", 32'(tick), 32'd0);
    chk("stopstart_cfg_ready", 32'(cfg_ready), 32'd1);
    cyc();
    chk("stopstart_stay_idle", 32'(busy), 32'd0);
    configure(1, 1, 1'b0);
    push(1, 1'b0); push(1, 1'b1);
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      wait_tick(50, n);
      chk("newcfg_period", 32'(n), 32'd2);
    end
    chk("newcfg_done_state", 32'(busy), 32'd0);

    // Asynchronous reset mid-cycle while running with irq set.
    configure(3, 5, 1'b1);
    push(1, 1'b0);
    pulse_start();
    wait_tick(50, n);
    chk("pre_rst_tick", 32'(n), 32'd4);
    cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_tick", 32'(tick), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // Defaults restored: div 7, limit 15, periodic.
    for (int i = 1; i <= 15; i++) push(i, 1'b0);
    push(0, 1'b1);
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      wait_tick(50, n);
      chk("def_cfg_period", 32'(n), 32'd8);
    end
    chk("def_cfg_periodic_busy", 32'(busy), 32'd1);
    pulse_stop();
    repeat (3) cyc();
    chk("sb_leftover", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
